// File: rtl/tree_sum_accumulator.sv
// Row accumulator for tree-adder partial sums with a FWFT result FIFO.
// Define TREE_ACC_SEQ_CHECK_EN to compile in the tile-order checker (drives seq_err).
module tree_sum_accumulator #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ACC_WIDTH       = 32,
  parameter int unsigned ADDRESS_WIDTH_I = 8,
  parameter int unsigned ADDRESS_WIDTH_K = 8,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      sum_in,
  input  logic [ADDRESS_WIDTH_I-1:0] addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0] addr_k_in,
  input  logic                       val_in,
  input  logic [ADDRESS_WIDTH_K-1:0] cfg_k_last,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic [ADDRESS_WIDTH_I-1:0] out_addr_i,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       seq_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e                     state_q, state_d;
  logic [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic [ADDRESS_WIDTH_K-1:0] k_next_q, k_next_d;
  logic [ACC_WIDTH-1:0]       sum_ext, acc_sum;

  logic                       push;
  logic [ACC_WIDTH-1:0]       push_data;
  logic [ADDRESS_WIDTH_I-1:0] push_addr;

`ifdef TREE_ACC_SEQ_CHECK_EN
  // Row tag is only consulted by the order checker.
  logic [ADDRESS_WIDTH_I-1:0] cur_i_q, cur_i_d;
  logic                       seq_err_q, seq_err_d;
`endif

  assign sum_ext = ACC_WIDTH'(sum_in);
  assign acc_sum = acc_q + sum_ext;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    k_next_d  = k_next_q;
    push      = 1'b0;
    push_data = acc_sum;
    push_addr = addr_i_in;
`ifdef TREE_ACC_SEQ_CHECK_EN
    cur_i_d   = cur_i_q;
    seq_err_d = seq_err_q;
`endif
    if (val_in) begin
      if (addr_k_in == '0) begin
`ifdef TREE_ACC_SEQ_CHECK_EN
        if (state_q == StAccum) seq_err_d = 1'b1;
        cur_i_d = addr_i_in;
`endif
        acc_d    = sum_ext;
        k_next_d = ADDRESS_WIDTH_K'(1);
        state_d  = StAccum;
        // Single-tile rows complete on their first beat.
        if (cfg_k_last == '0) begin
          push      = 1'b1;
          push_data = sum_ext;
          state_d   = StIdle;
        end
      end else if (state_q == StAccum) begin
`ifdef TREE_ACC_SEQ_CHECK_EN
        if ((addr_k_in != k_next_q) || (addr_i_in != cur_i_q)) begin
          seq_err_d = 1'b1;
          state_d   = StIdle;
        end else
`endif
        begin
          acc_d    = acc_sum;
          k_next_d = k_next_q + ADDRESS_WIDTH_K'(1);
          if (addr_k_in == cfg_k_last) begin
            push    = 1'b1;
            state_d = StIdle;
          end
        end
      end else begin
`ifdef TREE_ACC_SEQ_CHECK_EN
        seq_err_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      k_next_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      k_next_q <= k_next_d;
    end
  end

`ifdef TREE_ACC_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_i_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      cur_i_q   <= cur_i_d;
      seq_err_q <= seq_err_d;
    end
  end
  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  // Result FIFO: registered write, first-word-fall-through read.
  logic [ACC_WIDTH-1:0]       mem_data [FIFO_DEPTH];
  logic [ADDRESS_WIDTH_I-1:0] mem_addr [FIFO_DEPTH];
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic                       full, pop, wr_en;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop   = out_val & out_rdy;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (wr_en && !pop)      count_d = count_q + CntW'(1);
    else if (!wr_en && pop) count_d = count_q - CntW'(1);
    if (push && !wr_en) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= push_data;
      mem_addr[wr_ptr_q] <= push_addr;
    end
  end

  assign out_val     = (count_q != '0);
  assign out_data    = out_val ? mem_data[rd_ptr_q] : '0;
  assign out_addr_i  = out_val ? mem_addr[rd_ptr_q] : '0;
  assign almost_full = (count_q >= CntW'(FIFO_DEPTH - 1));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Directed self-checking bench for tree_sum_accumulator (default and 8-bit accumulator builds).
module tb_tree_sum_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  sum_in = '0;
  logic [7:0]  addr_i_in = '0;
  logic [7:0]  addr_k_in = '0;
  logic        val_in = 1'b0;
  logic [7:0]  cfg_k_last = '0;
  logic        out_rdy = 1'b0;

  logic [31:0] out_data;
  logic [7:0]  out_addr_i;
  logic        out_val, almost_full, overflow, seq_err;

  logic [7:0]  out_data8;
  logic [7:0]  out_addr_i8;
  logic        out_val8, almost_full8, overflow8, seq_err8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tree_sum_accumulator dut (
    .clk(clk), .reset(reset), .sum_in(sum_in), .addr_i_in(addr_i_in), .addr_k_in(addr_k_in),
    .val_in(val_in), .cfg_k_last(cfg_k_last), .out_data(out_data), .out_addr_i(out_addr_i),
    .out_val(out_val), .out_rdy(out_rdy), .almost_full(almost_full), .overflow(overflow),
    .seq_err(seq_err)
  );

  tree_sum_accumulator #(.ACC_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .sum_in(sum_in), .addr_i_in(addr_i_in), .addr_k_in(addr_k_in),
    .val_in(val_in), .cfg_k_last(cfg_k_last), .out_data(out_data8), .out_addr_i(out_addr_i8),
    .out_val(out_val8), .out_rdy(out_rdy), .almost_full(almost_full8), .overflow(overflow8),
    .seq_err(seq_err8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] k, input logic [7:0] i, input logic [7:0] s);
    @(negedge clk);
    val_in    = 1'b1;
    addr_k_in = k;
    addr_i_in = i;
    sum_in    = s;
  endtask

  task automatic idle();
    @(negedge clk);
    val_in = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    val_in = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_out_val", out_val, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr_i, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_seq_err", seq_err, 0);
    @(negedge clk);
    reset = 1'b1;

    // Four-tile row 10+20+30+40
    out_rdy    = 1'b1;
    cfg_k_last = 8'd3;
    beat(0, 5, 10);
    beat(1, 5, 20);
    beat(2, 5, 30);
    beat(3, 5, 40);
    check("row4_no_early_val", out_val, 0);
    idle();
    check("row4_val", out_val, 1);
    check("row4_data", out_data, 100);
    check("row4_addr", out_addr_i, 5);
    idle();
    check("row4_popped", out_val, 0);

    // Wrap in an 8-bit accumulator: 200+100 = 44 mod 256
    pulse_reset();
    cfg_k_last = 8'd1;
    beat(0, 2, 200);
    beat(1, 2, 100);
    idle();
    check("wrap8_data", out_data8, 44);
    check("wrap8_overflow", overflow8, 0);
    check("wide_data", out_data, 300);
    idle();

    // Fill with out_rdy low, then one drop
    pulse_reset();
    out_rdy    = 1'b0;
    cfg_k_last = 8'd0;
    beat(0, 1, 11);
    beat(0, 2, 22);
    beat(0, 3, 33);
    check("fill2_almost_full", almost_full, 0);
    beat(0, 4, 44);
    check("fill3_almost_full", almost_full, 1);
    beat(0, 5, 55);
    check("fill4_overflow", overflow, 0);
    idle();
    check("fill5_overflow", overflow, 1);
    check("fill_head_data", out_data, 11);
    idle();
    check("stall_head_data", out_data, 11);
    check("stall_head_addr", out_addr_i, 1);
    out_rdy = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check("drain_data", out_data, 32'(j * 11));
      check("drain_addr", out_addr_i, 32'(j));
      @(negedge clk);
    end
    check("drain_empty", out_val, 0);
    check("drain_overflow_sticky", overflow, 1);

    // Push and pop together on a full FIFO
    pulse_reset();
    out_rdy = 1'b0;
    beat(0, 1, 11);
    beat(0, 2, 22);
    beat(0, 3, 33);
    beat(0, 4, 44);
    idle();
    check("full_almost_full", almost_full, 1);
    beat(0, 5, 55);
    out_rdy = 1'b1;
    idle();
    out_rdy = 1'b0;
    check("pushpop_overflow", overflow, 0);
    check("pushpop_head", out_data, 22);
    out_rdy = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      check("pushpop_drain", out_data, 32'(j * 11));
      @(negedge clk);
    end
    check("pushpop_empty", out_val, 0);

    // Tile-order violation k=0, k=2 with cfg_k_last=2
    pulse_reset();
    cfg_k_last = 8'd2;
    beat(0, 7, 5);
    beat(2, 7, 6);
    idle();
`ifdef TREE_ACC_SEQ_CHECK_EN
    check("seq_err_set", seq_err, 1);
    check("seq_no_result", out_val, 0);
`else
    check("seq_err_tied", seq_err, 0);
    check("skip_result", out_data, 11);
`endif
    idle();
    // Non-zero tile in IDLE is discarded even when it matches cfg_k_last
    beat(2, 9, 50);
    idle();
    check("idle_beat_discard", out_val, 0);
    beat(0, 8, 1);
    beat(1, 8, 2);
    beat(2, 8, 3);
    idle();
    check("clean_row_data", out_data, 6);
    check("clean_row_addr", out_addr_i, 8);
    idle();

    // Reset mid-row discards the partial
    pulse_reset();
    cfg_k_last = 8'd3;
    beat(0, 3, 9);
    beat(1, 3, 9);
    @(negedge clk);
    val_in = 1'b0;
    reset  = 1'b0;
    #1;
    check("midrst_out_val", out_val, 0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    check("midrst_no_partial", out_val, 0);
    for (int j = 0; j < 4; j++) beat(8'(j), 4, 1);
    idle();
    check("midrst_data", out_data, 4);
    check("midrst_addr", out_addr_i, 4);
    check("midrst_overflow", overflow, 0);
    check("midrst_seq_err", seq_err, 0);
    check("midrst_almost_full", almost_full, 0);
    idle();
    check("midrst_single", out_val, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tree_sum_accumulator.md
TREE_SUM_ACCUMULATOR -- requirements
Module: tree_sum_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of incoming partial sums.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: accumulator and result width (ACC_WIDTH >= DATA_WIDTH).
REQ-003 SHALL have parameter ADDRESS_WIDTH_I, default 8: output-row tag width.
REQ-004 SHALL have parameter ADDRESS_WIDTH_K, default 8: tile-index tag width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >= 2): result buffer entries.
REQ-006 SHALL have ports:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset (asserted at 0)
  sum_in  in  DATA_WIDTH  partial sum from the tree adder
  addr_i_in  in  ADDRESS_WIDTH_I  row tag
  addr_k_in  in  ADDRESS_WIDTH_K  tile index
  val_in  in  1  beat valid; no backpressure, so a beat is consumed every cycle val_in=1
  cfg_k_last  in  ADDRESS_WIDTH_K  index of the final tile per row
  out_data  out  ACC_WIDTH  accumulated row result
  out_addr_i  out  ADDRESS_WIDTH_I  row tag of out_data
  out_val  out  1  result valid
  out_rdy  in  1  downstream ready
  almost_full  out  1  FIFO holds >= FIFO_DEPTH-1 entries
  overflow  out  1  sticky: result dropped
  seq_err  out  1  sticky: tile-order violation

Function
REQ-007 SHALL zero-extend sum_in to ACC_WIDTH and add modulo 2^ACC_WIDTH (unsigned, wrap, no saturation).
REQ-008 SHALL use two states: IDLE (no partial) and ACCUM (partial held in acc, cur_i, k_next).
REQ-009 On a beat with addr_k_in==0: acc <= sum_in, cur_i <= addr_i_in, k_next <= 1; go to ACCUM, from either state.
REQ-010 On a beat with addr_k_in!=0 in ACCUM: acc <= acc + sum_in, k_next <= k_next+1.
REQ-011 On a beat with addr_k_in==cfg_k_last: push {final sum, addr_i_in} to the FIFO and go to IDLE; with cfg_k_last==0 every addr_k 0 beat pushes sum_in directly.
REQ-012 cfg_k_last SHALL be sampled on each beat; it must stay stable for the duration of a row.
REQ-013 Push-to-out_val latency SHALL be 1 cycle when the FIFO is empty (registered FIFO write, first-word-fall-through read).
REQ-014 A pop SHALL occur on any cycle with out_val=1 and out_rdy=1; out_data/out_addr_i SHALL stay stable while out_val=1 and out_rdy=0.
REQ-015 Push when full SHALL be accepted if a pop occurs in the same cycle; otherwise the result is dropped, overflow sets, and FIFO contents are unchanged.
REQ-016 Simultaneous push and pop on an empty FIFO SHALL NOT bypass: out_val rises the next cycle.
REQ-017 A non-zero addr_k beat in IDLE SHALL be discarded, with the state remaining IDLE.

Reset
REQ-018 Reset SHALL asynchronously force IDLE, acc=0, k_next=0, FIFO empty, out_val=0, out_data=0, out_addr_i=0, almost_full=0, overflow=0, seq_err=0.
REQ-019 A row in progress at reset SHALL be discarded; no partial result is emitted after release.
REQ-020 Release SHALL be synchronised to clk; beats are accepted from the first rising edge with reset=1.

Configuration
REQ-021 Macro TREE_ACC_SEQ_CHECK_EN SHALL compile in the order checker.
REQ-022 With the macro defined, in ACCUM a beat with addr_k_in!=0 and (addr_k_in!=k_next or addr_i_in!=cur_i) SHALL set seq_err, be discarded, and return to IDLE; the REQ-017 case also sets seq_err.
REQ-023 With the macro defined, an addr_k==0 beat in ACCUM SHALL set seq_err and still restart per REQ-009.
REQ-024 Without the macro, seq_err SHALL be tied 0, tags SHALL be unchecked, and REQ-009/010/011/017 apply as written.

Verification
REQ-025 cfg_k_last=3, row i=5 with sums 10,20,30,40 on k=0..3, out_rdy=1 -> one result: out_data=100, out_addr_i=5, out_val high 1 cycle after the k=3 beat.
REQ-026 ACC_WIDTH=8, cfg_k_last=1, sums 200,100 -> out_data=44 (wrap), overflow=0.
REQ-027 out_rdy=0, FIFO_DEPTH=4, five single-tile rows (cfg_k_last=0) -> almost_full=1 after the 3rd push, 4 entries held, overflow=1 after the 5th; popping then returns rows 1-4 in order.
REQ-028 Full FIFO, push and pop in the same cycle -> push accepted, overflow stays 0, entry count stays 4.
REQ-029 With TREE_ACC_SEQ_CHECK_EN, cfg_k_last=2, beats k=0,k=2 -> seq_err=1, no result; a following k=0,1,2 row with sums 1,2,3 -> out_data=6.
REQ-030 Reset asserted mid-row (after k=1 of 4) and released, then a clean row of sums 1,1,1,1 -> only out_data=4 emitted, all flags 0.
